// File: rtl/bist_mem_controller.sv
// rtl/bist_mem_controller.sv - March-test BIST sequencer (MATS+ / March C-) for a small RAM under test
module bist_mem_controller #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              BIST_CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              ABORT,
    input  logic [12:0]       CONF,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    output logic              MEM_WE,
    output logic              MEM_RE,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              FAIL,
    output logic [ADDR_W-1:0] FAIL_ADDR,
    output logic [CNT_W-1:0]  FAIL_CNT
);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_CMP, S_FINISH} state_t;

    // rd/wr: element reads/writes; rv/wv: background polarity; down: address order; last: final element
    typedef struct packed {
        logic rd;
        logic rv;
        logic wr;
        logic wv;
        logic down;
        logic last;
    } elem_t;

    function automatic elem_t elem_info(input logic alg, input logic [2:0] idx);
        elem_t e;
        e = '0;
        if (!alg) begin
            case (idx)
                3'd0:    e = 6'b001000;
                3'd1:    e = 6'b101100;
                3'd2:    e = 6'b111011;
                default: e = 6'b000001;
            endcase
        end else begin
            case (idx)
                3'd0:    e = 6'b001000;
                3'd1:    e = 6'b101100;
                3'd2:    e = 6'b111000;
                3'd3:    e = 6'b101110;
                3'd4:    e = 6'b111010;
                3'd5:    e = 6'b100001;
                default: e = 6'b000001;
            endcase
        end
        return e;
    endfunction

    state_t              state_q, state_d;
    logic                alg_q, alg_d;
    logic                stop_q, stop_d;
    logic [DATA_W-1:0]   pat_q, pat_d;
    logic [2:0]          elem_q, elem_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d;
    logic [DATA_W-1:0]   exp_val;
    elem_t               cur, nxt, d_info;
    logic                mis, at_end, start_run, mis_upd;
    logic [ADDR_W-1:0]   step_addr, next_first;

    assign BUSY = (state_q == S_WR) || (state_q == S_RD) || (state_q == S_CMP);

    always_comb begin
        state_d    = state_q;
        alg_d      = alg_q;
        stop_d     = stop_q;
        pat_d      = pat_q;
        elem_d     = elem_q;
        addr_d     = MEM_ADDR;
        wdata_d    = MEM_WDATA;
        start_run  = 1'b0;
        mis_upd    = 1'b0;
        MEM_WE     = 1'b0;
        MEM_RE     = 1'b0;
        cur        = elem_info(alg_q, elem_q);
        nxt        = elem_info(alg_q, elem_q + 3'd1);
        exp_val    = cur.rv ? ~pat_q : pat_q;
        mis        = (MEM_RDATA != exp_val);
        at_end     = cur.down ? (MEM_ADDR == '0) : (MEM_ADDR == {ADDR_W{1'b1}});
        step_addr  = cur.down ? (MEM_ADDR - ADDR_W'(1)) : (MEM_ADDR + ADDR_W'(1));
        next_first = nxt.down ? {ADDR_W{1'b1}} : '0;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    start_run = 1'b1;
                    alg_d     = CONF[1];
                    stop_d    = CONF[2];
                    pat_d     = CONF[4 +: DATA_W];
                    elem_d    = '0;
                    if (CONF[0]) begin
                        addr_d  = '0;
                        state_d = S_WR;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_WR: begin
                MEM_WE = 1'b1;
                if (ABORT) begin
                    state_d = S_IDLE;
                end else if (!at_end) begin
                    addr_d = step_addr;
                end else if (cur.last) begin
                    state_d = S_FINISH;
                end else begin
                    elem_d  = elem_q + 3'd1;
                    addr_d  = next_first;
                    state_d = S_RD;
                end
            end
            S_RD: begin
                MEM_RE  = 1'b1;
                state_d = ABORT ? S_IDLE : S_CMP;
            end
            S_CMP: begin
                // a stop-on-fail miscompare suppresses the element's write in this cycle
                MEM_WE = cur.wr && !(mis && stop_q);
                if (ABORT) begin
                    state_d = S_IDLE;
                end else begin
                    mis_upd = mis;
                    if (mis && stop_q) begin
                        state_d = S_FINISH;
                    end else if (!at_end) begin
                        addr_d  = step_addr;
                        state_d = S_RD;
                    end else if (cur.last) begin
                        state_d = S_FINISH;
                    end else begin
                        elem_d  = elem_q + 3'd1;
                        addr_d  = next_first;
                        state_d = S_RD;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        d_info = elem_info(alg_d, elem_d);
        if ((state_d == S_WR || state_d == S_RD || state_d == S_CMP) && d_info.wr)
            wdata_d = d_info.wv ? ~pat_d : pat_d;
    end

    always_ff @(posedge BIST_CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            alg_q     <= 1'b0;
            stop_q    <= 1'b0;
            pat_q     <= '0;
            elem_q    <= '0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
            DONE      <= 1'b0;
            FAIL      <= 1'b0;
            FAIL_ADDR <= '0;
            FAIL_CNT  <= '0;
        end else begin
            state_q   <= state_d;
            alg_q     <= alg_d;
            stop_q    <= stop_d;
            pat_q     <= pat_d;
            elem_q    <= elem_d;
            MEM_ADDR  <= addr_d;
            MEM_WDATA <= wdata_d;
            if (start_run) begin
                DONE      <= 1'b0;
                FAIL      <= 1'b0;
                FAIL_ADDR <= '0;
                FAIL_CNT  <= '0;
            end else if (mis_upd) begin
                FAIL <= 1'b1;
                if (!FAIL)
                    FAIL_ADDR <= MEM_ADDR;
                if (FAIL_CNT != {CNT_W{1'b1}})
                    FAIL_CNT <= FAIL_CNT + CNT_W'(1);
            end
            if (state_d == S_FINISH)
                DONE <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bist_mem_controller.sv
// tb/tb_bist_mem_controller.sv - scoreboard bench for bist_mem_controller
module tb_bist_mem_controller;

    typedef struct packed {
        logic       we;
        logic [3:0] addr;
        logic [7:0] data;
    } op_t;

    logic        clk = 1'b0;
    logic        rst, start, abort_r;
    logic [12:0] conf;
    logic [3:0]  mem_addr, fail_addr;
    logic [7:0]  mem_wdata, rdata, fail_cnt;
    logic        mem_we, mem_re, busy, done, fail;

    op_t         exp_q[$];
    op_t         mon_e;
    int          checks = 0;
    int          errors = 0;
    int          busy_cnt = 0;
    bit          fault_en = 1'b0;
    logic [7:0]  mem [16];

    always #5 clk = ~clk;

    bist_mem_controller #(.ADDR_W(4), .DATA_W(8), .CNT_W(8)) dut (
        .BIST_CLK (clk),
        .RST      (rst),
        .START    (start),
        .ABORT    (abort_r),
        .CONF     (conf),
        .MEM_ADDR (mem_addr),
        .MEM_WDATA(mem_wdata),
        .MEM_WE   (mem_we),
        .MEM_RE   (mem_re),
        .MEM_RDATA(rdata),
        .BUSY     (busy),
        .DONE     (done),
        .FAIL     (fail),
        .FAIL_ADDR(fail_addr),
        .FAIL_CNT (fail_cnt)
    );

    // RAM under test with an optional stuck-at-0 on bit 0 of word 5
    always @(posedge clk) begin
        if (mem_we === 1'b1)
            mem[mem_addr] <= (fault_en && mem_addr == 4'd5) ? (mem_wdata & 8'hFE) : mem_wdata;
        if (mem_re === 1'b1)
            rdata <= mem[mem_addr];
    end

    always @(negedge clk) begin
        if (busy === 1'b1)
            busy_cnt++;
        if (mem_we === 1'b1 || mem_re === 1'b1) begin
            checks++;
            if (mem_we && mem_re) begin
                errors++;
                $display("FAIL op_strobes actual we=1 re=1 required exactly one");
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL op_unexpected actual we=%0b addr=%0d data=%02h required no op", mem_we, mem_addr, mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (mem_we !== mon_e.we || mem_addr !== mon_e.addr || (mon_e.we && mem_wdata !== mon_e.data)) begin
                    errors++;
                    $display("FAIL op_seq actual we=%0b addr=%0d data=%02h required we=%0b addr=%0d data=%02h",
                             mem_we, mem_addr, mem_wdata, mon_e.we, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_elem(input bit down, input bit rd, input bit wr, input logic [7:0] wv, input int stop_at);
        for (int i = 0; i < 16; i++) begin
            int a;
            a = down ? 15 - i : i;
            if (rd) exp_q.push_back({1'b0, 4'(a), 8'h00});
            if (a == stop_at) return;
            if (wr) exp_q.push_back({1'b1, 4'(a), wv});
        end
    endtask

    task automatic push_march_c(input logic [7:0] p, input int stop_at);
        push_elem(1'b0, 1'b0, 1'b1, p, -1);
        push_elem(1'b0, 1'b1, 1'b1, ~p, -1);
        push_elem(1'b0, 1'b1, 1'b1, p, stop_at);
        if (stop_at < 0) begin
            push_elem(1'b1, 1'b1, 1'b1, ~p, -1);
            push_elem(1'b1, 1'b1, 1'b1, p, -1);
            push_elem(1'b0, 1'b1, 1'b0, 8'h00, -1);
        end
    endtask

    task automatic push_mats(input logic [7:0] p);
        push_elem(1'b0, 1'b0, 1'b1, p, -1);
        push_elem(1'b0, 1'b1, 1'b1, ~p, -1);
        push_elem(1'b1, 1'b1, 1'b1, p, -1);
    endtask

    task automatic pulse_start(input logic [12:0] c);
        @(posedge clk); #1;
        busy_cnt = 0;
        conf  = c;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic normal_run(input string name);
        push_march_c(8'h00, -1);
        pulse_start(13'h0003);
        wait_done(name);
        check({name, "_busy_cycles"}, busy_cnt, 176);
        check({name, "_busy_at_done"}, busy, 0);
        check({name, "_fail"}, fail, 0);
        check({name, "_fail_cnt"}, fail_cnt, 0);
        check({name, "_ops_left"}, exp_q.size(), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort_r = 1'b0; conf = '0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        rdata = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fail", fail, 0);
        check("rst_fail_addr", fail_addr, 0);
        check("rst_fail_cnt", fail_cnt, 0);
        check("rst_we", mem_we, 0);
        check("rst_re", mem_re, 0);

        normal_run("marchc_clean");

        fault_en = 1'b1;
        push_march_c(8'h00, -1);
        pulse_start(13'h0003);
        wait_done("marchc_fault");
        check("marchc_fault_busy_cycles", busy_cnt, 176);
        check("marchc_fault_fail", fail, 1);
        check("marchc_fault_addr", fail_addr, 5);
        check("marchc_fault_cnt", fail_cnt, 2);
        check("marchc_fault_ops_left", exp_q.size(), 0);

        push_march_c(8'h00, 5);
        pulse_start(13'h0007);
        wait_done("stop_fail");
        check("stop_fail_busy_cycles", busy_cnt, 60);
        check("stop_fail_done", done, 1);
        check("stop_fail_fail", fail, 1);
        check("stop_fail_cnt", fail_cnt, 1);
        check("stop_fail_addr", fail_addr, 5);
        check("stop_fail_ops_left", exp_q.size(), 0);
        fault_en = 1'b0;

        push_mats(8'h55);
        pulse_start(13'h0551);
        wait_done("mats");
        check("mats_busy_cycles", busy_cnt, 80);
        check("mats_fail", fail, 0);
        check("mats_ops_left", exp_q.size(), 0);

        pulse_start(13'h0002);
        @(negedge clk);
        check("disabled_done", done, 1);
        check("disabled_busy", busy, 0);
        check("disabled_fail", fail, 0);
        repeat (3) @(negedge clk);
        check("disabled_busy_cycles", busy_cnt, 0);

        push_march_c(8'h00, -1);
        pulse_start(13'h0003);
        repeat (20) @(posedge clk);
        #1 conf = 13'h0551; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done("restart_ignored");
        check("restart_ignored_busy_cycles", busy_cnt, 176);
        check("restart_ignored_ops_left", exp_q.size(), 0);

        push_march_c(8'h00, -1);
        pulse_start(13'h0003);
        repeat (39) @(posedge clk);
        #1 abort_r = 1'b1;
        @(posedge clk); #1 abort_r = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_we", mem_we, 0);
        check("abort_re", mem_re, 0);
        check("abort_busy_cycles", busy_cnt, 40);
        check("abort_ops_left", exp_q.size(), 120);
        exp_q.delete();
        normal_run("after_abort");

        push_march_c(8'h00, -1);
        pulse_start(13'h0003);
        repeat (39) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_fail", fail, 0);
        check("midrst_fail_addr", fail_addr, 0);
        check("midrst_fail_cnt", fail_cnt, 0);
        check("midrst_addr", mem_addr, 0);
        check("midrst_wdata", mem_wdata, 0);
        check("midrst_we", mem_we, 0);
        check("midrst_re", mem_re, 0);
        check("midrst_ops_left", exp_q.size(), 120);
        exp_q.delete();
        normal_run("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
